ov7670_capture: RTL and testbench

Camera-side capture stage feeding the 80x60 frame buffer that drives the OLED video path. Samples the OV7670 parallel bus (PCLK/VSYNC/HREF/D[7:0]) in the system clock domain and reassembles RGB565 byte pairs. Decimates 640x480 by 8 in both axes and emits 12-bit RGB444 write transactions (address, data, strobe) into the buffer. Start/stop is frame-granular so the display never shows a torn frame.

---
 rtl/ov7670_capture.sv | 200 ++++++++++++++++++++
 tb/tb_ov7670_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the OV7670 parallel bus in the system clock domain, pairs RGB565
// bytes into pixels, decimates by 2**DecimLog2 in both axes and writes RGB444 pixels into the
// frame buffer. Capture starts and stops only on frame boundaries.
module ov7670_capture #(
  parameter int unsigned SrcCols   = 640,
  parameter int unsigned SrcRows   = 480,
  parameter int unsigned DecimLog2 = 3,
  parameter int unsigned ImgCols   = 80,
  parameter int unsigned ImgRows   = 60,
  parameter int unsigned NbImgPxls = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  input  logic                 cam_pclk,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_d,
  output logic                 wr_en,
  output logic [NbImgPxls-1:0] wr_addr,
  output logic [11:0]          wr_data,
  output logic                 frame_done,
  output logic                 capturing
);

  localparam int unsigned ColW    = $clog2(SrcCols + 1);
  localparam int unsigned RowW    = $clog2(SrcRows + 1);
  localparam int unsigned ColIdxW = $clog2(ImgCols);
  localparam int unsigned RowIdxW = $clog2(ImgRows);

  typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

  // Synchronizer taps: [0] = s1, [1] = s2 (decision value), [2] = s3 (edge reference)
  logic [2:0] pclk_q, vsync_q, href_q;
  logic [7:0] d_s1_q, d_s2_q;

  // Bring the camera bus into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_q  <= '0;
      vsync_q <= '0;
      href_q  <= '0;
      d_s1_q  <= '0;
      d_s2_q  <= '0;
    end else begin
      pclk_q  <= {pclk_q[1:0], cam_pclk};
      vsync_q <= {vsync_q[1:0], cam_vsync};
      href_q  <= {href_q[1:0], cam_href};
      d_s1_q  <= cam_d;
      d_s2_q  <= d_s1_q;
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall, href_rise, href_fall, href_s2;
  assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
  assign vsync_rise = vsync_q[1] & ~vsync_q[2];
  assign vsync_fall = ~vsync_q[1] & vsync_q[2];
  assign href_rise  = href_q[1] & ~href_q[2];
  assign href_fall  = ~href_q[1] & href_q[2];
  assign href_s2    = href_q[1];

  state_e          state_q;
  logic            capturing_q;
  logic            fd_a_q;
  logic            byte_phase_q;
  logic [6:0]      hi_q;         // first byte minus R5[0], which truncation drops anyway
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;

  // Stage A: one completed in-range source pixel
  logic            px_vld_q;
  logic [11:0]     px_data_q;
  logic [ColW-1:0] px_col_q;
  logic [RowW-1:0] px_row_q;

  // A line start restarts pairing and column count even if a byte lands on the same cycle
  logic            phase_cur;
  logic [ColW-1:0] col_cur;
  logic            col_full, row_full, take_byte;
  assign phase_cur = href_rise ? 1'b0 : byte_phase_q;
  assign col_cur   = href_rise ? '0 : col_q;
  assign col_full  = (col_cur == ColW'(SrcCols));
  assign row_full  = (row_q == RowW'(SrcRows));
  assign take_byte = pclk_rise & href_s2;

  // Frame FSM, byte pairing and source counters; vsync edges win over href/pclk activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      capturing_q  <= 1'b0;
      fd_a_q       <= 1'b0;
      byte_phase_q <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      px_vld_q     <= 1'b0;
      px_data_q    <= '0;
      px_col_q     <= '0;
      px_row_q     <= '0;
    end else begin
      px_vld_q <= 1'b0;
      fd_a_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture_en) state_q <= StSync;
        end
        StSync: begin
          if (vsync_fall) begin
            state_q      <= StActive;
            capturing_q  <= 1'b1;
            col_q        <= '0;
            row_q        <= '0;
            byte_phase_q <= 1'b0;
          end
        end
        StActive: begin
          if (vsync_rise) begin
            capturing_q <= 1'b0;
            if (row_full) begin
              fd_a_q  <= 1'b1;
              state_q <= capture_en ? StSync : StIdle;
            end else begin
              // Short frame: drop it silently and resync on the next one
              state_q <= StSync;
            end
          end else begin
            if (href_rise) begin
              byte_phase_q <= 1'b0;
              col_q        <= '0;
            end
            if (href_fall && !row_full) row_q <= row_q + 1'b1;
            if (take_byte) begin
              byte_phase_q <= ~phase_cur;
              if (!phase_cur) begin
                hi_q <= {d_s2_q[7:4], d_s2_q[2:0]};
              end else if (!col_full && !row_full) begin
                col_q     <= col_cur + 1'b1;
                px_vld_q  <= 1'b1;
                // {R5[4:1], G6[5:2], B5[4:1]} of the RGB565 word {hi, d}
                px_data_q <= {hi_q[6:3], hi_q[2:0], d_s2_q[7], d_s2_q[4:1]};
                px_col_q  <= col_cur;
                px_row_q  <= row_q;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decimation keep rule and buffer address of the stage-A pixel
  logic                 keep;
  logic [ColIdxW-1:0]   col_idx;
  logic [RowIdxW-1:0]   row_idx;
  logic [NbImgPxls-1:0] addr_calc;
  assign keep    = (px_col_q[DecimLog2-1:0] == '0) && (px_row_q[DecimLog2-1:0] == '0);
  assign col_idx = ColIdxW'(px_col_q >> DecimLog2);
  assign row_idx = RowIdxW'(px_row_q >> DecimLog2);
  // Constant multiply; for 80 columns this reduces to (r << 6) + (r << 4) + c
  assign addr_calc = NbImgPxls'(row_idx) * NbImgPxls'(ImgCols) + NbImgPxls'(col_idx);

  logic                 wb_vld_q, wr_en_q, fd_b_q, frame_done_q;
  logic [NbImgPxls-1:0] wb_addr_q, wr_addr_q;
  logic [11:0]          wb_data_q, wr_data_q;

  // Two more register stages to the buffer port; address/data hold between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_vld_q     <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fd_b_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wb_vld_q <= px_vld_q & keep;
      if (px_vld_q) begin
        wb_addr_q <= addr_calc;
        wb_data_q <= px_data_q;
      end
      wr_en_q <= wb_vld_q;
      if (wb_vld_q) begin
        wr_addr_q <= wb_addr_q;
        wr_data_q <= wb_data_q;
      end
      fd_b_q       <= fd_a_q;
      frame_done_q <= fd_b_q;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign capturing  = capturing_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: drives randomized camera frames into a reduced-size capture block and
// checks every buffer write and frame_done pulse against a pixel-level reference model.
module tb_ov7670_capture;

  localparam int SC = 32;  // source columns
  localparam int SR = 16;  // source rows
  localparam int DL = 3;
  localparam int IC = 4;   // buffer columns
  localparam int D  = 1 << DL;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_d;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        capturing;

  ov7670_capture #(
    .SrcCols  (SC),
    .SrcRows  (SR),
    .DecimLog2(DL),
    .ImgCols  (IC),
    .ImgRows  (2),
    .NbImgPxls(13)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .capture_en(capture_en),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_d     (cam_d),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .capturing (capturing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t exp_q[$];
  bit  m_run  = 1'b0;  // current frame is being captured
  bit  m_sync = 1'b0;  // block will capture the next frame regardless of capture_en
  bit  fd_exp = 1'b0;
  int  fd_cyc = 0;
  int  wr_seen = 0;
  int  fd_seen = 0;
  int  last_addr = 0;
  int  last_data = 0;

  function automatic int exp_rgb444(input int p);
    int r5, g6, b5;
    r5 = (p / 2048) % 32;
    g6 = (p / 32) % 64;
    b5 = p % 32;
    return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin : mon
    wr_t e;
    if (wr_en) begin
      wr_seen++;
      check_eq("wr_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", int'(wr_addr), e.addr);
        check_eq("wr_data", int'(wr_data), e.data);
        check_eq("wr_latency", cyc, e.cyc);
        last_addr = e.addr;
        last_data = e.data;
      end
    end
    if (frame_done) begin
      fd_seen++;
      check_eq("fd_expected", int'(fd_exp), 1);
      check_eq("fd_latency", cyc, fd_cyc);
      check_eq("fd_no_wr", int'(wr_en), 0);
      fd_exp = 1'b0;
    end
  end

  // Advance n clocks and land 2 time units after the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_byte(input logic [7:0] b, output int rise_cyc);
    cam_d = b;
    tick($urandom_range(2, 3));
    cam_pclk = 1'b1;
    rise_cyc = cyc;
    tick(2);
    cam_pclk = 1'b0;
  endtask

  function automatic logic [15:0] pixel(input int mode, input int c, input int r);
    case (mode)
      1:       return 16'hF81F;
      2:       return 16'h07E0;
      3:       return (c == 16 && r == 8) ? 16'hFFFF : 16'h0000;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wr_en"}, int'(wr_en), 0);
    check_eq({tag, "_wr_addr"}, int'(wr_addr), 0);
    check_eq({tag, "_wr_data"}, int'(wr_data), 0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
    check_eq({tag, "_capturing"}, int'(capturing), 0);
  endtask

  task automatic drive_frame(input int nrows, input int ncols, input int mode, input bit extra,
                             input int ce_drop_row, input int rst_row);
    int          wr0, fd0, exp_writes, rc;
    bit          fd_want;
    logic [15:0] p;
    wr0        = wr_seen;
    fd0        = fd_seen;
    exp_writes = 0;
    fd_want    = 1'b0;
    cam_vsync  = 1'b0;
    m_run      = m_sync || capture_en;
    m_sync     = 1'b0;
    tick(8);
    for (int r = 0; r < nrows; r++) begin
      if (r == ce_drop_row) capture_en = 1'b0;
      if (r == 1) check_eq("capturing_in_frame", int'(capturing), int'(m_run));
      cam_href = 1'b1;
      for (int c = 0; c < ncols; c++) begin
        if (r == rst_row && c == 10) begin
          reset = 1'b1;
          #1;
          check_outputs_zero("rst_mid");
          exp_writes -= exp_q.size();
          exp_q.delete();
          m_run     = 1'b0;
          m_sync    = 1'b0;
          last_addr = 0;
          last_data = 0;
          tick(3);
          reset = 1'b0;
        end
        p = pixel(mode, c, r);
        drive_byte(p[15:8], rc);
        drive_byte(p[7:0], rc);
        if (m_run && c < SC && r < SR && c % D == 0 && r % D == 0) begin
          exp_q.push_back('{addr: (r / D) * IC + c / D, data: exp_rgb444(int'(p)),
                            cyc: rc + 5});
          exp_writes++;
        end
      end
      if (extra) drive_byte(8'($urandom_range(0, 255)), rc);
      cam_href = 1'b0;
      tick($urandom_range(4, 10));
    end
    tick(4);
    cam_vsync = 1'b1;
    if (m_run) begin
      if (nrows >= SR) begin
        fd_want = 1'b1;
        fd_exp  = 1'b1;
        fd_cyc  = cyc + 5;
        m_sync  = capture_en;
      end else begin
        m_sync = 1'b1;
      end
    end
    m_run = 1'b0;
    tick(16);
    check_eq("frame_writes", wr_seen - wr0, exp_writes);
    check_eq("frame_pending", exp_q.size(), 0);
    check_eq("frame_done_count", fd_seen - fd0, int'(fd_want));
    check_eq("capturing_after", int'(capturing), 0);
    check_eq("hold_addr", int'(wr_addr), last_addr);
    check_eq("hold_data", int'(wr_data), last_data);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    capture_en = 1'b0;
    cam_pclk   = 1'b0;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_d      = 8'h00;
    tick(3);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    tick(4);
    capture_en = 1'b1;
    tick(8);

    drive_frame(SR, SC, 0, 1'b0, -1, -1);      // random full frame
    drive_frame(SR, SC, 1, 1'b0, -1, -1);      // 0xF81F -> 0xF0F
    drive_frame(SR, SC, 2, 1'b0, -1, -1);      // 0x07E0 -> 0x0F0
    drive_frame(SR, SC, 3, 1'b0, -1, -1);      // single marker at (16, 8)
    drive_frame(SR + 1, SC + 2, 0, 1'b1, -1, -1);  // over-long lines/frame, dangling bytes
    drive_frame(5, SC, 0, 1'b0, -1, -1);       // short frame
    drive_frame(SR, SC, 0, 1'b0, -1, -1);      // recovers with a full frame
    drive_frame(SR, SC, 0, 1'b0, 3, -1);       // capture_en dropped mid-frame
    drive_frame(SR, SC, 0, 1'b0, -1, -1);      // stopped: no writes
    capture_en = 1'b1;
    tick(4);
    drive_frame(SR, SC, 0, 1'b0, -1, 6);       // reset mid-line
    drive_frame(SR, SC, 0, 1'b0, -1, -1);      // next frame from address 0

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
